// File: rtl/shift_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_pkg
// Shared definitions for the shift-register sequencer: the controller state
// enumeration and the direction encoding used on the dir input.
// No ports (package).
// ---------------------------------------------------------------------------
package shift_seq_ctrl_pkg;

  // Controller states; encoding is left to the enum default
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_DONE,
    ST_ABORT
  } state_t;

  // Direction encoding shared with the host side
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_step_counter.sv
// ---------------------------------------------------------------------------
// shift_step_counter
// Loadable CW-bit down-counter with enable and zero flag. Load has priority
// over enable; the counter holds at zero instead of wrapping.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset, clears the count
//   load     in   load load_val into the count
//   en       in   decrement by one (ignored while count is zero)
//   load_val in   CW-bit value to load
//   count    out  current count
//   zero     out  high when count is zero
// ---------------------------------------------------------------------------
module shift_step_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          zero
);

  // Count register: load wins over decrement, and a zero count never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
// Sequencer for the left/right shift register. Takes one command per start
// pulse (direction, step count, optional pre-clear), drives the register's
// clear / shift-right / shift-left controls cycle by cycle, then pulses done
// (or aborted if the command was cut short).
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   command strobe, only accepted in IDLE
//   dir        in   0 = shift right, 1 = shift left (latched with start)
//   steps      in   CW-bit shift count (latched with start)
//   pre_clr    in   clear register before shifting (sampled with start)
//   abort      in   terminate the running command (CLEAR/SHIFT only)
//   sr_clr     out  shift register clear control
//   sr_r       out  shift register shift-right control
//   sr_l       out  shift register shift-left control
//   busy       out  high in CLEAR and SHIFT
//   done       out  one-cycle pulse on normal completion
//   aborted    out  one-cycle pulse on abort completion
//   steps_left out  remaining shift cycles including the current one
// ---------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          dir,
  input  logic [CW-1:0] steps,
  input  logic          pre_clr,
  input  logic          abort,
  output logic          sr_clr,
  output logic          sr_r,
  output logic          sr_l,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [CW-1:0] steps_left
);

  state_t        state, state_nxt;
  logic          dir_q;
  logic          accept;
  logic [CW-1:0] count;
  logic          count_zero;
  logic          last_step;

  assign accept    = (state == ST_IDLE) && start;
  assign last_step = (count == CW'(1));

  // The counter is loaded with the requested steps when a command is
  // accepted and only ticks during SHIFT, so it already holds the right
  // value when CLEAR hands over to SHIFT.
  shift_step_counter #(.CW(CW)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .en       (state == ST_SHIFT),
    .load_val (steps),
    .count    (count),
    .zero     (count_zero)
  );

  // State register plus the latched direction; the direction only changes
  // when a command is accepted so stray dir toggles mid-command are harmless
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      dir_q <= DIR_RIGHT;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dir_q <= dir;
      end
    end
  end

  // Next-state logic. Abort outranks completion in CLEAR and SHIFT; in the
  // IDLE decision the raw steps input is used because the counter has not
  // been loaded yet.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (pre_clr)             state_nxt = ST_CLEAR;
          else if (steps != '0)    state_nxt = ST_SHIFT;
          else                     state_nxt = ST_DONE;
        end
      end
      ST_CLEAR: begin
        if (abort)                 state_nxt = ST_ABORT;
        else if (count_zero)       state_nxt = ST_DONE;
        else                       state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort)                 state_nxt = ST_ABORT;
        else if (last_step)        state_nxt = ST_DONE;
      end
      ST_DONE:                     state_nxt = ST_IDLE;
      ST_ABORT:                    state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Output decode straight from the state register; only one state drives
  // strobes at a time, which keeps the three controls mutually exclusive.
  always_comb begin
    sr_clr     = 1'b0;
    sr_r       = 1'b0;
    sr_l       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    steps_left = '0;
    unique case (state)
      ST_CLEAR: begin
        sr_clr     = 1'b1;
        busy       = 1'b1;
        steps_left = count;
      end
      ST_SHIFT: begin
        sr_r       = (dir_q == DIR_RIGHT);
        sr_l       = (dir_q == DIR_LEFT);
        busy       = 1'b1;
        steps_left = count;
      end
      ST_DONE:  done    = 1'b1;
      ST_ABORT: aborted = 1'b1;
      default: ;
    endcase
  end

endmodule
